intbus_initiator: RTL and testbench

Register-bus initiator that turns a queued stream of read/write commands into single-beat transactions on the internal register bus (intbus). It is the master-side counterpart of the `regs_file` responder. It lets PL logic, such as an FFT/butterfly sequencer, program and read back register-file blocks (twiddles, CUT, operands, results) without the CPU/AXI3 path. It contains a command FIFO, a transaction FSM and an optional read timeout.

---
 rtl/intbus_initiator.sv | 187 ++++++++++++++++++
 tb/tb_intbus_initiator.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intbus_initiator.sv
// intbus_initiator: queues read/write commands and plays them out as single-beat intbus transactions.
// Optional read timeout: `define INTBUS_INIT_TIMEOUT_EN (undefined = wait for bus_rvalid forever).
module intbus_initiator #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_wr,
  output logic                  bus_rd,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_rvalid,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // rsp_valid is a one-cycle pulse with no backpressure, rsp_rdata/rsp_err qualify it.

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_out_of_range
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t                  state_q;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_d;
  logic                    ready_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [DATA_WIDTH-1:0]   bus_wdata_q;
  logic                    bus_wr_q;
  logic                    bus_rd_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  logic                    push;
  logic                    pop;
  logic [EW-1:0]           head;
  logic                    head_we;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH-1:0]   head_wdata;

  // ready_q already encodes !full, so a pop in a full cycle cannot admit a push.
  assign push       = cmd_valid && ready_q;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_we    = head[EW-1];
  assign head_addr  = head[EW-2 -: ADDR_WIDTH];
  assign head_wdata = head[DATA_WIDTH-1:0];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_wdata};
    end
  end

`ifdef INTBUS_INIT_TIMEOUT_EN
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEADBEEF);
  logic [7:0] wait_cnt_q;
  logic       rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef INTBUS_INIT_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      count_q     <= count_d;
      ready_q     <= (count_d != CW'(FIFO_DEPTH));
      busy_q      <= (state_q != IDLE) || (count_q != '0);
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            bus_addr_q  <= head_addr;
            bus_wdata_q <= head_wdata;
            if (head_we) begin
              bus_wr_q <= 1'b1;
              state_q  <= WRITE;
            end else begin
              bus_rd_q <= 1'b1;
              state_q  <= READ_REQ;
            end
          end
        end
        WRITE: state_q <= IDLE;
        READ_REQ: begin
`ifdef INTBUS_INIT_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= READ_WAIT;
        end
        READ_WAIT: begin
          // Responder data takes priority over a timeout landing in the same cycle.
          if (bus_rvalid) begin
            rsp_rdata_q <= bus_rdata;
            rsp_valid_q <= 1'b1;
`ifdef INTBUS_INIT_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= RESP;
          end
`ifdef INTBUS_INIT_TIMEOUT_EN
          else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
            rsp_rdata_q <= ERR_DATA;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wr    = bus_wr_q;
  assign bus_rd    = bus_rd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_intbus_initiator.sv
// Bench for intbus_initiator: random command stream against a cycle-timing reference model.
module tb_intbus_initiator;

  localparam int AW      = 14;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000000000;
  localparam logic [DW-1:0] ERR_DATA = 32'hDEADBEEF;
`ifdef INTBUS_INIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_wr;
  logic          bus_rd;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_rvalid = 1'b0;
  logic          busy;
  logic [2:0]    dbg_state;

  intbus_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected transaction: command plus predicted strobe and response timing
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            acc;
    int            pop;
    int            strobe;
    int            dly;
    logic [DW-1:0] rdat;
    int            rsp_cyc;
    logic          err;
    logic [DW-1:0] rsp_data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          rsp_q[$];
  int            fsm_free = 0;
  int            pend = 0;
  logic [DW-1:0] pend_data = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Offer one command; on acceptance, predict its pop, strobe and response cycles.
  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int dly, input logic [DW-1:0] rdat);
    int   waited;
    int   s;
    exp_t e;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check_eq("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    s          = (cyc + 1 > fsm_free) ? cyc + 1 : fsm_free;
    e          = '0;
    e.we       = we;
    e.addr     = addr;
    e.wdata    = wdata;
    e.acc      = cyc;
    e.pop      = s;
    e.strobe   = s + 1;
    e.dly      = dly;
    e.rdat     = rdat;
    if (we) begin
      fsm_free = s + 2;
    end else if (TO_EN && (dly == 0 || dly > TIMEOUT)) begin
      e.rsp_cyc  = s + 1 + TIMEOUT + 1;
      e.err      = 1'b1;
      e.rsp_data = ERR_DATA;
      fsm_free   = s + 1 + TIMEOUT + 2;
    end else if (dly == 0) begin
      e.rsp_cyc = NEVER;
      fsm_free  = NEVER;
    end else begin
      e.rsp_cyc  = s + 1 + dly + 1;
      e.err      = 1'b0;
      e.rsp_data = rdat;
      fsm_free   = s + 1 + dly + 2;
    end
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0) && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check_eq("drain_outstanding", exp_q.size() + rsp_q.size(), 0);
    repeat (2) @(negedge clk);
    check_eq("idle_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    check_eq({tag, "_bus_addr"},  bus_addr,  0);
    check_eq({tag, "_bus_wdata"}, bus_wdata, 0);
    check_eq({tag, "_bus_wr"},    bus_wr,    0);
    check_eq({tag, "_bus_rd"},    bus_rd,    0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check_eq({tag, "_rsp_err"},   rsp_err,   0);
    check_eq({tag, "_busy"},      busy,      0);
    check_eq({tag, "_state"},     dbg_state, 0);
  endtask

  // Responder and scoreboard, both on the falling edge.
  exp_t m;
  int   occ;
  always @(negedge clk) begin
    bus_rvalid = 1'b0;
    bus_rdata  = $urandom;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = pend_data;
      end
    end
    if (!rst) begin
      occ = 0;
      foreach (exp_q[i]) if (exp_q[i].acc < cyc && exp_q[i].pop >= cyc) occ++;
      check_eq("cmd_ready", cmd_ready, (occ < DEPTH));

      if (bus_wr || bus_rd) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_strobe", bus_wr | bus_rd, 0);
        end else begin
          m = exp_q.pop_front();
          check_eq("strobe_cycle", cyc, m.strobe);
          check_eq("strobe_wr", bus_wr, m.we);
          check_eq("strobe_rd", bus_rd, !m.we);
          check_eq("bus_addr", bus_addr, m.addr);
          if (m.we) check_eq("bus_wdata", bus_wdata, m.wdata);
          if (bus_rd) begin
            pend      = m.dly;
            pend_data = m.rdat;
            rsp_q.push_back(m);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].strobe < cyc) begin
        check_eq("missing_strobe", cyc, exp_q[0].strobe);
        void'(exp_q.pop_front());
      end

      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check_eq("unexpected_rsp", rsp_valid, 0);
        end else begin
          m = rsp_q.pop_front();
          check_eq("rsp_cycle", cyc, m.rsp_cyc);
          check_eq("rsp_err", rsp_err, m.err);
          check_eq("rsp_rdata", rsp_rdata, m.rsp_data);
        end
      end else if (rsp_q.size() != 0 && rsp_q[0].rsp_cyc < cyc) begin
        check_eq("missing_rsp", cyc, rsp_q[0].rsp_cyc);
        void'(rsp_q.pop_front());
      end
    end
  end

  initial begin
    int stall_d;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // single write, busy rise and fall
    send(1'b1, 14'h005, 32'h00AB0CD0, 0, '0);
    check_eq("busy_n1", busy, 0);
    @(negedge clk);
    check_eq("busy_n2", busy, 1);
    @(negedge clk);
    check_eq("busy_n3", busy, 1);
    @(negedge clk);
    check_eq("busy_n4", busy, 0);
    drain();

    // minimum-latency read
    send(1'b0, 14'h003, '0, 1, 32'h12345678);
    drain();

    // FIFO full behind a stalled read
    stall_d = TO_EN ? 0 : 30;
    send(1'b0, 14'h020, '0, stall_d, 32'h55AA55AA);
    for (int i = 0; i < 4; i++) send(1'b1, AW'(48 + i), $urandom, 0, '0);
    check_eq("full_ready", cmd_ready, 0);
    send(1'b1, 14'h034, 32'hA5A5_0005, 0, '0);
    drain();

`ifdef INTBUS_INIT_TIMEOUT_EN
    send(1'b0, 14'h011, '0, 0, '0);
    drain();
    send(1'b0, 14'h012, '0, 20, 32'hCAFEF00D);
    drain();
    send(1'b0, 14'h013, '0, TIMEOUT, 32'h0BADF00D);
    drain();
`endif

    // random traffic
    for (int i = 0; i < 60; i++) begin
      send(1'(($urandom_range(0, 1))), AW'($urandom), $urandom,
           int'($urandom_range(1, 12)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // reset during READ_WAIT with two commands queued
    send(1'b0, 14'h2A5, 32'h1111_2222, 0, '0);
    send(1'b1, 14'h1C3, 32'h3333_4444, 0, '0);
    send(1'b1, 14'h1C4, 32'h5555_6666, 0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    rsp_q.delete();
    pend     = 0;
    fsm_free = 0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    repeat (12) @(negedge clk);
    send(1'b1, 14'h077, 32'h7777_0001, 0, '0);
    send(1'b0, 14'h078, '0, 3, 32'h7777_0002);
    drain();

    check_eq("final_exp_q", exp_q.size(), 0);
    check_eq("final_rsp_q", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
